adder_sched: RTL and testbench
==============================

# adder_sched

Round-robin scheduler sharing one pipelined 2-to-1 adder among `N_REQ` requesters. Arbitrates per-requester valid/ready operand channels, issues at most one operation per cycle into the adder, tags each operation with its requester ID through a delay line matched to the adder latency, and returns results on a single credit-protected response channel. The adder instance sits outside this block; the pair forms the shared arithmetic unit of the datapath.

## Interface
- `N_REQ`, 4: number of requesters, 2..16
- `WIDTH`, 256: operand/sum width
- `LATENCY`, 4: adder cycles from `add_in_valid` to `add_out_valid`, ≥1
- `FIFO_DEPTH`, 8: response FIFO entries, power of 2, ≥2
- `clk` in 1: clock
- `resetn` in 1: asynchronous active-low reset
- `req_valid` in N_REQ: per-requester operation valid
- `req_ready` out N_REQ: per-requester accept (one-hot or zero)
- `req_a` in N_REQ*WIDTH: operand A, requester i at `[i*WIDTH +: WIDTH]`
- `req_b` in N_REQ*WIDTH: operand B, same packing
- `req_cin` in N_REQ: carry-in per requester
- `add_in_valid` out 1: issue strobe to adder
- `add_a`, `add_b` out WIDTH: registered operands to adder
- `add_cin` out 1: registered carry-in to adder
- `add_s` in WIDTH: adder sum
- `add_cout` in 1: adder carry-out
- `add_out_valid` in 1: adder result valid
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: response consumer accept
- `rsp_id` out IDW: requester index, IDW = max(1, clog2(N_REQ))
- `rsp_s` out WIDTH, `rsp_cout` out 1: result
- `err_latency` out 1: sticky latency-mismatch flag

## Operation
- Credits: `credit` counter, range 0..FIFO_DEPTH, reset FIFO_DEPTH. Issue (grant taken) decrements; response handshake (`rsp_valid & rsp_ready`) increments; both in same cycle → unchanged. No issue when `credit == 0`, so the FIFO never overflows and the adder, which cannot stall, never drops a result.
- Arbitration: round-robin pointer `ptr`, reset 0. When `credit > 0`, grant the first i with `req_valid[i]`, scanning ptr, ptr+1, … mod N_REQ. `req_ready[i]` = grant[i], combinational, asserted only with `req_valid[i]`. On grant, `ptr` ← (i+1) mod N_REQ; with no grant, `ptr` holds.
- Issue register: on grant, capture `req_a/b/cin` of winner into `add_a/b/cin`, assert `add_in_valid` next cycle; otherwise `add_in_valid`=0 and operands hold.
- Tag line: LATENCY-stage shift of {valid, id} launched alongside the issue register, so the tag emerges in the same cycle as `add_out_valid`.
- Capture: when the emerging tag is valid, write {id, `add_s`, `add_cout`} into the FIFO. First-word fall-through: `rsp_valid` = not empty; pop on handshake. Simultaneous push/pop on full/empty is legal and preserves count. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: tag line, FIFO, credit, and ptr are cleared; in-flight operations are lost. `resetn` also resets the adder. Adder results with no valid tag are discarded.

## Timing
- Reset values: `req_ready`=0, `add_in_valid`=0, `add_a/b/cin`=0, `rsp_valid`=0, `rsp_id/s/cout`=0 (FIFO storage reset), `err_latency`=0.
- Grant in cycle T → `add_in_valid` in T+1 → `add_out_valid`/tag in T+1+LATENCY → `rsp_valid` in T+2+LATENCY (FIFO empty). Minimum request-to-response latency is LATENCY+2.
- Throughput is one operation per cycle while credits remain. With `rsp_ready` held low, exactly FIFO_DEPTH operations issue, then `req_ready` stays 0.

## Configuration
- `ADDER_SCHED_CHECK_EN` defined: each cycle, compare the emerging tag valid with `add_out_valid`. On mismatch, set `err_latency` (sticky until reset) and drop any untagged result.
- `ADDER_SCHED_CHECK_EN` undefined: `err_latency` is tied 0 and `add_out_valid` is ignored; capture is driven by the tag alone.

## Structure
- Package `adder_sched_pkg`: IDW function `id_width(n)`, typedef `adder_rsp_t` {id, s, cout}, credit width constant derivation.
- Sub-module `adder_sched_rr_arb` (N_REQ-wide round-robin arbiter with enable and pointer update). FIFO and tag line stay inline.

## Test plan
- Single request, requester 2, A=5, B=7, cin=1, LATENCY=4 → `rsp_valid` at T+6, `rsp_id`=2, `rsp_s`=13, `rsp_cout`=0.
- All 4 requesters valid continuously → grants 0,1,2,3,0,… one per cycle; responses return in the same ID order.
- `rsp_ready`=0, FIFO_DEPTH=8, constant requests → exactly 8 issues, then `req_ready`=0. Raise `rsp_ready` → one new issue per pop; credit never exceeds 8.
- A=all-ones, B=1, cin=0 → `rsp_s`=0, `rsp_cout`=1 (full-width carry).
- `resetn` pulsed with 3 operations in flight → after release no `rsp_valid`, `credit`=8, `ptr`=0, first grant goes to the lowest valid index.
- With `ADDER_SCHED_CHECK_EN`, model the adder at LATENCY+1 → `err_latency` rises at the first tag emergence and stays 1.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared helpers and types for the adder scheduler.
//   id_width(n)      : requester index width, max(1, clog2(n))
//   credit_width(d)  : width holding a credit count 0..d
//   adder_rsp_t      : response payload {id, s, cout} at the default build size
package adder_sched_pkg;

   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned credit_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   localparam int unsigned DEF_N_REQ = 4;
   localparam int unsigned DEF_WIDTH = 256;
   localparam int unsigned DEF_IDW   = id_width(DEF_N_REQ);

   typedef struct packed {
      logic [DEF_IDW-1:0]   id;
      logic [DEF_WIDTH-1:0] s;
      logic                 cout;
   } adder_rsp_t;

endpackage

// File: rtl/adder_sched_rr_arb.sv
// adder_sched_rr_arb: N-wide round-robin arbiter with enable.
//   clk, resetn  : clock, async active-low reset
//   en           : allow a grant this cycle
//   req          : request vector
//   grant_c      : one-hot (or zero) grant, combinational
//   grant_id_c   : index of the granted requester, combinational
// The search starts at ptr; after a grant ptr moves just past the winner.
module adder_sched_rr_arb
   import adder_sched_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = id_width(N)
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           en,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant_c,
   output logic [IDW-1:0] grant_id_c
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;

   // Scan ptr, ptr+1, ... mod N and grant the first requester found.
   always_comb begin
      logic           found;
      logic [IDW-1:0] sel;
      int unsigned    idx;
      grant_c    = '0;
      grant_id_c = '0;
      ptr_nxt    = ptr;
      found      = 1'b0;
      sel        = '0;
      idx        = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = IDW'(idx);
         if (en && !found && req[sel]) begin
            found        = 1'b1;
            grant_c[sel] = 1'b1;
            grant_id_c   = sel;
         end
      end
      if (found) begin
         ptr_nxt = (grant_id_c == IDW'(N - 1)) ? '0 : grant_id_c + IDW'(1);
      end
   end

   // Round-robin pointer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ptr <= '0;
      else         ptr <= ptr_nxt;
   end

endmodule

// File: rtl/adder_sched.sv
// adder_sched: round-robin scheduler sharing one external pipelined adder.
//   clk, resetn                 : clock, async active-low reset
//   req_valid/ready             : per-requester operand handshake (ready is comb.)
//   req_a/req_b/req_cin         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_in_valid/a/b/cin        : registered issue to the adder
//   add_s/add_cout/add_out_valid: adder result
//   rsp_valid/ready/id/s/cout   : response channel (first-word fall-through FIFO)
//   err_latency                 : sticky tag/adder alignment error
// Optional build macro ADDER_SCHED_CHECK_EN enables the latency checker; without
// it err_latency is 0 and the tag line alone decides capture.
module adder_sched
   import adder_sched_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned WIDTH      = 256,
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned IDW        = id_width(N_REQ)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ-1:0]       req_cin,
   output logic                   add_in_valid,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_cin,
   input  logic [WIDTH-1:0]       add_s,
   input  logic                   add_cout,
   input  logic                   add_out_valid,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_s,
   output logic                   rsp_cout,
   output logic                   err_latency
);

   localparam int unsigned CW = credit_width(FIFO_DEPTH);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = IDW + WIDTH + 1;

   logic [CW-1:0]    credit;
   logic [N_REQ-1:0] grant;
   logic [IDW-1:0]   grant_id;
   logic             arb_en;
   logic             issue;
   logic             pop;
   logic             push;

   // No grant while in reset or while every FIFO slot is already promised.
   assign arb_en = resetn && (credit != '0);

   adder_sched_rr_arb #(.N(N_REQ), .IDW(IDW)) u_arb (
      .clk        (clk),
      .resetn     (resetn),
      .en         (arb_en),
      .req        (req_valid),
      .grant_c    (grant),
      .grant_id_c (grant_id)
   );

   assign req_ready = grant;
   assign issue     = |grant;
   assign pop       = rsp_valid & rsp_ready;

   // Credits track free FIFO slots, counting results still inside the adder.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)              credit <= CW'(FIFO_DEPTH);
      else if (issue && !pop)   credit <= credit - CW'(1);
      else if (pop && !issue)   credit <= credit + CW'(1);
   end

   // Issue register feeding the adder.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         add_in_valid <= 1'b0;
         add_a        <= '0;
         add_b        <= '0;
         add_cin      <= 1'b0;
      end else begin
         add_in_valid <= issue;
         if (issue) begin
            add_a   <= req_a[32'(grant_id)*WIDTH +: WIDTH];
            add_b   <= req_b[32'(grant_id)*WIDTH +: WIDTH];
            add_cin <= req_cin[grant_id];
         end
      end
   end

   // Tag line: stage 0 is aligned with add_in_valid, stage LATENCY with add_out_valid.
   logic [LATENCY:0] tag_v;
   logic [IDW-1:0]   tag_id [LATENCY+1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tag_v <= '0;
         for (int unsigned i = 0; i <= LATENCY; i++) tag_id[i] <= '0;
      end else begin
         tag_v     <= {tag_v[LATENCY-1:0], issue};
         tag_id[0] <= grant_id;
         for (int unsigned i = 1; i <= LATENCY; i++) tag_id[i] <= tag_id[i-1];
      end
   end

`ifdef ADDER_SCHED_CHECK_EN
   // Capture only tagged results; any misalignment latches the error flag.
   assign push = tag_v[LATENCY] & add_out_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                             err_latency <= 1'b0;
      else if (tag_v[LATENCY] != add_out_valid) err_latency <= 1'b1;
   end
`else
   logic unused_add_out_valid;
   assign unused_add_out_valid = add_out_valid;
   assign push                 = tag_v[LATENCY];
   assign err_latency          = 1'b0;
`endif

   // Response FIFO; credits guarantee it never overflows.
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= {tag_id[LATENCY], add_s, add_cout};
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   assign rsp_valid                   = (wr_ptr != rd_ptr);
   assign {rsp_id, rsp_s, rsp_cout}   = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: scoreboard bench for adder_sched with a behavioural adder.
module tb_adder_sched;
   import adder_sched_pkg::*;

   localparam int unsigned N_REQ      = 4;
   localparam int unsigned WIDTH      = 256;
   localparam int unsigned LATENCY    = 4;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned IDW        = id_width(N_REQ);
   localparam int unsigned CHK_W      = 264;

   logic                   clk;
   logic                   resetn;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       req_cin;
   logic                   add_in_valid;
   logic [WIDTH-1:0]       add_a;
   logic [WIDTH-1:0]       add_b;
   logic                   add_cin;
   logic [WIDTH-1:0]       add_s;
   logic                   add_cout;
   logic                   add_out_valid;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [WIDTH-1:0]       rsp_s;
   logic                   rsp_cout;
   logic                   err_latency;

   adder_sched #(
      .N_REQ(N_REQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .add_in_valid(add_in_valid), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout), .add_out_valid(add_out_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
      .err_latency(err_latency)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural adder with LATENCY cycles from add_in_valid to add_out_valid.
   logic [LATENCY-1:0] am_v;
   logic [WIDTH:0]     am_sum [LATENCY];
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         am_v <= '0;
         for (int i = 0; i < int'(LATENCY); i++) am_sum[i] <= '0;
      end else begin
         am_v      <= {am_v[LATENCY-2:0], add_in_valid};
         am_sum[0] <= (WIDTH+1)'(add_a) + (WIDTH+1)'(add_b) + (WIDTH+1)'(add_cin);
         for (int i = 1; i < int'(LATENCY); i++) am_sum[i] <= am_sum[i-1];
      end
   end
   assign add_out_valid     = am_v[LATENCY-1];
   assign {add_cout, add_s} = am_sum[LATENCY-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [CHK_W-1:0] got,
                        input logic [CHK_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   adder_rsp_t       exp_q[$];
   int               grant_log[$];
   int               cyc = 0;
   int               n_issue = 0;
   int               n_rsp = 0;
   int               rsp_valid_cnt = 0;
   int               last_grant_cyc = 0;
   int               last_rsp_cyc = 0;
   logic [IDW-1:0]   obs_id;
   logic [WIDTH-1:0] obs_s;
   logic             obs_cout;
   logic [N_REQ-1:0] granted = '0;
   bit               refill = 1'b0;

   always @(posedge clk) cyc++;

   // Monitor: record grants into the scoreboard and compare every response.
   always @(negedge clk) begin
      adder_rsp_t e;
      int         gid;
      gid = 0;
      if (resetn) begin
         check("ready_legal", CHK_W'(((req_ready & ~req_valid) == '0) && $onehot0(req_ready)), CHK_W'(1));
         check("credit_max", CHK_W'(dut.credit <= FIFO_DEPTH), CHK_W'(1));
         granted = req_ready;
         if (|req_ready) begin
            for (int i = 0; i < int'(N_REQ); i++) if (req_ready[i]) gid = i;
            e.id = IDW'(gid);
            {e.cout, e.s} = (WIDTH+1)'(req_a[gid*WIDTH +: WIDTH])
                          + (WIDTH+1)'(req_b[gid*WIDTH +: WIDTH])
                          + (WIDTH+1)'(req_cin[gid]);
            exp_q.push_back(e);
            grant_log.push_back(gid);
            n_issue++;
            last_grant_cyc = cyc;
         end
         if (rsp_valid) rsp_valid_cnt++;
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            last_rsp_cyc = cyc;
            obs_id   = rsp_id;
            obs_s    = rsp_s;
            obs_cout = rsp_cout;
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", CHK_W'(1), CHK_W'(0));
            end else begin
               e = exp_q.pop_front();
               check("rsp_id", CHK_W'(rsp_id), CHK_W'(e.id));
               check("rsp_s", CHK_W'(rsp_s), CHK_W'(e.s));
               check("rsp_cout", CHK_W'(rsp_cout), CHK_W'(e.cout));
            end
         end
      end else begin
         granted = '0;
      end
   end

   task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic c);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_cin[i]              = c;
   endtask

   task automatic rand_op(input int i);
      set_op(i, {8{$urandom()}}, {8{$urandom()}}, 1'($urandom_range(1, 0)));
   endtask

   // Driver: after each accepted request either load fresh operands or drop valid.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (granted[i]) begin
               if (refill) rand_op(i);
               else        req_valid[i] = 1'b0;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_rsp(input string tag, input int n0);
      int k;
      k = 0;
      while (n_rsp == n0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check(tag, CHK_W'(n_rsp != n0), CHK_W'(1));
      step(1);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || rsp_valid) && k < 200) begin
         step(1);
         k++;
      end
      check("drain", CHK_W'(exp_q.size()), CHK_W'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base;
      int exp_id;
      int n0;
      resetn    = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", CHK_W'(req_ready), CHK_W'(0));
      check("rst_add_in_valid", CHK_W'(add_in_valid), CHK_W'(0));
      check("rst_add_a", CHK_W'(add_a), CHK_W'(0));
      check("rst_add_b", CHK_W'(add_b), CHK_W'(0));
      check("rst_add_cin", CHK_W'(add_cin), CHK_W'(0));
      check("rst_rsp_valid", CHK_W'(rsp_valid), CHK_W'(0));
      check("rst_rsp_id", CHK_W'(rsp_id), CHK_W'(0));
      check("rst_rsp_s", CHK_W'(rsp_s), CHK_W'(0));
      check("rst_rsp_cout", CHK_W'(rsp_cout), CHK_W'(0));
      check("rst_err_latency", CHK_W'(err_latency), CHK_W'(0));
      check("rst_credit", CHK_W'(dut.credit), CHK_W'(FIFO_DEPTH));
      req_valid = '0;
      resetn    = 1'b1;
      step(2);

      // Single request: requester 2, 5 + 7 + 1.
      rsp_ready = 1'b1;
      n0 = n_rsp;
      set_op(2, WIDTH'(5), WIDTH'(7), 1'b1);
      req_valid[2] = 1'b1;
      wait_rsp("t1_timeout", n0);
      check("t1_latency", CHK_W'(last_rsp_cyc - last_grant_cyc), CHK_W'(LATENCY + 2));
      check("t1_id", CHK_W'(obs_id), CHK_W'(2));
      check("t1_s", CHK_W'(obs_s), CHK_W'(13));
      check("t1_cout", CHK_W'(obs_cout), CHK_W'(0));
      drain();

      // All requesters valid: one grant per cycle, rotating from just past 2.
      base   = grant_log.size();
      refill = 1'b1;
      for (int i = 0; i < int'(N_REQ); i++) rand_op(i);
      req_valid = '1;
      step(24);
      req_valid = '0;
      refill    = 1'b0;
      drain();
      check("t2_count", CHK_W'(grant_log.size() - base), CHK_W'(24));
      exp_id = 3;
      for (int j = 0; j < 24 && base + j < grant_log.size(); j++) begin
         check("t2_order", CHK_W'(grant_log[base + j]), CHK_W'(exp_id));
         exp_id = (exp_id + 1) % int'(N_REQ);
      end

      // Backpressure: exactly FIFO_DEPTH issues, then resume on pops.
      rsp_ready = 1'b0;
      refill    = 1'b1;
      base      = n_issue;
      for (int i = 0; i < int'(N_REQ); i++) rand_op(i);
      req_valid = '1;
      step(20);
      check("t3_issues", CHK_W'(n_issue - base), CHK_W'(FIFO_DEPTH));
      @(negedge clk);
      check("t3_ready", CHK_W'(req_ready), CHK_W'(0));
      check("t3_credit", CHK_W'(dut.credit), CHK_W'(0));
      check("t3_rsp_valid", CHK_W'(rsp_valid), CHK_W'(1));
      step(1);
      rsp_ready = 1'b1;
      step(30);
      check("t3_resume", CHK_W'((n_issue - base) > int'(FIFO_DEPTH)), CHK_W'(1));
      req_valid = '0;
      refill    = 1'b0;
      drain();

      // Full-width carry: all-ones + 1.
      n0 = n_rsp;
      set_op(1, '1, WIDTH'(1), 1'b0);
      req_valid[1] = 1'b1;
      wait_rsp("t4_timeout", n0);
      check("t4_id", CHK_W'(obs_id), CHK_W'(1));
      check("t4_s", CHK_W'(obs_s), CHK_W'(0));
      check("t4_cout", CHK_W'(obs_cout), CHK_W'(1));
      drain();

      // Reset with three operations in flight.
      rsp_ready = 1'b0;
      base      = n_issue;
      for (int i = 0; i < 3; i++) rand_op(i);
      req_valid = 4'b0111;
      step(4);
      check("t5_issued", CHK_W'(n_issue - base), CHK_W'(3));
      resetn    = 1'b0;
      req_valid = '0;
      step(2);
      exp_q.delete();
      resetn = 1'b1;
      base   = rsp_valid_cnt;
      step(12);
      check("t5_no_rsp", CHK_W'(rsp_valid_cnt - base), CHK_W'(0));
      @(negedge clk);
      check("t5_credit", CHK_W'(dut.credit), CHK_W'(FIFO_DEPTH));
      check("t5_ptr", CHK_W'(dut.u_arb.ptr), CHK_W'(0));
      step(1);
      rand_op(1);
      rand_op(3);
      req_valid = 4'b1010;
      @(negedge clk);
      check("t5_first_grant", CHK_W'(req_ready), CHK_W'(4'b0010));
      step(1);
      rsp_ready = 1'b1;
      step(4);
      drain();

      check("err_latency", CHK_W'(err_latency), CHK_W'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
